day1_instruction_parser: RTL and testbench



---
 rtl/day1_pkg.sv | 38 +++
 rtl/day1_decimal_accumulator.sv | 46 ++++
 rtl/day1_instruction_parser.sv | 138 +++++++++++++
 tb/tb_day1_instruction_parser.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/day1_pkg.sv
// Shared definitions for the day-1 dial puzzle: ASCII codes,
// direction encoding and the instruction parser state.
package day1_pkg;

    localparam int unsigned DEF_COUNT_WIDTH = 16;

    localparam logic [7:0] CHAR_L     = 8'h4C;
    localparam logic [7:0] CHAR_R     = 8'h52;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_COMMA = 8'h2C;
    localparam logic [7:0] CHAR_0     = 8'h30;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } parser_state_e;

    function automatic logic is_space(input logic [7:0] c);
        return (c == CHAR_LF) || (c == CHAR_CR) ||
               (c == CHAR_SPACE) || (c == CHAR_COMMA);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CHAR_0) && (c <= (CHAR_0 + 8'd9));
    endfunction

    function automatic logic is_dir(input logic [7:0] c);
        return (c == CHAR_L) || (c == CHAR_R);
    endfunction

endpackage

// File: rtl/day1_decimal_accumulator.sv
// Saturating decimal accumulator: acc = acc*10 + digit, clamped to
// all-ones with a one-cycle overflow pulse on the offending digit.
module day1_decimal_accumulator #(
    parameter int unsigned W = 16
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         clear_i,
    input  logic         digit_i,
    input  logic [3:0]   value_i,
    output logic [W-1:0] count_o,
    output logic         overflow_o
);

    logic [W-1:0] acc_q, acc_d;
    logic [W+3:0] wide;
    logic         ovf;

    // acc*10 as (acc<<3)+(acc<<1); four spare bits hold any result
    always_comb begin
        wide = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
             + {{W{1'b0}}, value_i};
        ovf  = |wide[W+3:W];
    end

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (digit_i) begin
            acc_d = ovf ? {W{1'b1}} : wide[W-1:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign count_o    = acc_q;
    assign overflow_o = digit_i & ~clear_i & ovf;

endmodule

// File: rtl/day1_instruction_parser.sv
// ASCII byte stream to decoded dial rotations ("L68\n" -> dir/count),
// with sticky done/format_error flags and wrap-around statistics.
module day1_instruction_parser
    import day1_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned STAT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   byte_last,
    output logic                   byte_ready,
    output logic                   instruction_valid,
    input  logic                   instruction_ready,
    output logic                   direction,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   done,
    output logic                   format_error,
    output logic [STAT_WIDTH-1:0]  instructions_emitted,
    output logic [STAT_WIDTH-1:0]  error_count
);

    parser_state_e state_q, state_d;

    logic dir_q, dir_d;
    logic last_q, last_d;
    logic seen_q, seen_d;
    logic ovf_seen_q, ovf_seen_d;
    logic fmt_err_q;
    logic [STAT_WIDTH-1:0] emit_cnt_q, err_cnt_q;

    logic byte_xfer, ins_xfer;
    logic acc_clr, acc_dig, acc_ovf;
    logic err_evt, emit_evt;

    assign byte_xfer = byte_valid & byte_ready;
    assign ins_xfer  = instruction_valid & instruction_ready;

    day1_decimal_accumulator #(
        .W (COUNT_WIDTH)
    ) u_acc (
        .clock_i    (clock),
        .reset_n_i  (reset_n),
        .clear_i    (acc_clr),
        .digit_i    (acc_dig),
        .value_i    (byte_data[3:0]),
        .count_o    (count),
        .overflow_o (acc_ovf)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dir_q      <= DIR_LEFT;
            last_q     <= 1'b0;
            seen_q     <= 1'b0;
            ovf_seen_q <= 1'b0;
            fmt_err_q  <= 1'b0;
            emit_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_q     <= last_d;
            seen_q     <= seen_d;
            ovf_seen_q <= ovf_seen_d;
            fmt_err_q  <= fmt_err_q | err_evt;
            if (emit_evt) emit_cnt_q <= emit_cnt_q + STAT_WIDTH'(1);
            if (err_evt)  err_cnt_q  <= err_cnt_q + STAT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_d     = last_q | (byte_xfer & byte_last);
        seen_d     = seen_q;
        ovf_seen_d = ovf_seen_q;
        acc_clr    = 1'b0;
        acc_dig    = 1'b0;
        err_evt    = 1'b0;
        emit_evt   = 1'b0;
        unique case (state_q)
            IDLE: if (byte_xfer) begin
                if (is_dir(byte_data)) begin
                    dir_d      = (byte_data == CHAR_R) ? DIR_RIGHT : DIR_LEFT;
                    acc_clr    = 1'b1;
                    seen_d     = 1'b0;
                    ovf_seen_d = 1'b0;
                    err_evt    = byte_last;
                    state_d    = byte_last ? DONE : DIGITS;
                end else if (is_space(byte_data)) begin
                    if (byte_last) state_d = DONE;
                end else begin
                    err_evt = 1'b1;
                    if (byte_last) state_d = DONE;
                end
            end
            DIGITS: if (byte_xfer) begin
                if (is_digit(byte_data)) begin
                    acc_dig = 1'b1;
                    seen_d  = 1'b1;
                    // only the first overflow of a line is reported
                    if (acc_ovf && !ovf_seen_q) begin
                        err_evt    = 1'b1;
                        ovf_seen_d = 1'b1;
                    end
                    if (byte_last) state_d = EMIT;
                end else if (is_space(byte_data) && seen_q) begin
                    state_d = EMIT;
                end else begin
                    err_evt = 1'b1;
                    state_d = byte_last ? DONE : IDLE;
                end
            end
            EMIT: if (ins_xfer) begin
                emit_evt = 1'b1;
                state_d  = last_q ? DONE : IDLE;
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready        = (state_q == IDLE) || (state_q == DIGITS);
        instruction_valid = (state_q == EMIT);
        done              = (state_q == DONE);
    end

    assign direction            = dir_q;
    assign format_error         = fmt_err_q;
    assign instructions_emitted = emit_cnt_q;
    assign error_count          = err_cnt_q;

endmodule

// File: tb/tb_day1_instruction_parser.sv
// Directed bench for the day-1 instruction parser.
module tb_day1_instruction_parser;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic        instruction_valid;
    logic        instruction_ready = 1'b1;
    logic        direction;
    logic [15:0] count;
    logic        done;
    logic        format_error;
    logic [31:0] instructions_emitted;
    logic [31:0] error_count;

    int n_pass = 0;
    int n_total = 0;

    logic [16:0] rec[$];

    always #5 clock = ~clock;

    day1_instruction_parser dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .byte_valid           (byte_valid),
        .byte_data            (byte_data),
        .byte_last            (byte_last),
        .byte_ready           (byte_ready),
        .instruction_valid    (instruction_valid),
        .instruction_ready    (instruction_ready),
        .direction            (direction),
        .count                (count),
        .done                 (done),
        .format_error         (format_error),
        .instructions_emitted (instructions_emitted),
        .error_count          (error_count)
    );

    always @(posedge clock) begin
        if (reset_n && instruction_valid && instruction_ready)
            rec.push_back({direction, count});
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        repeat (2) @(negedge clock);
        rec.delete();
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        byte_valid = 1'b1;
        byte_data = b;
        byte_last = last;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!byte_ready) begin
            n_total++;
            $display("FAIL send_timeout byte=%h byte_ready=%b required 1",
                     b, byte_ready);
        end
        @(posedge clock);
        @(negedge clock);
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_final);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_final && (i == s.len() - 1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
        end
        n_total++;
        if (done !== 1'b1)
            $display("FAIL wait_done done=%b required 1", done);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({byte_ready, instruction_valid, direction, done, format_error} !== 5'b10000)
            $display("FAIL reset_flags got rdy/vld/dir/done/err=%b required 10000",
                     {byte_ready, instruction_valid, direction, done, format_error});
        else n_pass++;
        n_total++;
        if (count !== 16'd0)
            $display("FAIL reset_count got %0d required 0", count);
        else n_pass++;
        n_total++;
        if (instructions_emitted !== 32'd0 || error_count !== 32'd0)
            $display("FAIL reset_counters got %0d/%0d required 0/0",
                     instructions_emitted, error_count);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [16:0] e0, e1;
        e0 = {1'b0, 16'd68};
        e1 = {1'b1, 16'd48};
        do_reset();
        instruction_ready = 1'b1;
        send_str("L68\nR48\n", 1'b1);
        wait_done();
        n_total++;
        if (rec.size() !== 2)
            $display("FAIL basic_n got %0d required 2", rec.size());
        else n_pass++;
        if (rec.size() == 2) begin
            n_total++;
            if (rec[0] !== e0 || rec[1] !== e1)
                $display("FAIL basic_ins got %h,%h required %h,%h",
                         rec[0], rec[1], e0, e1);
            else n_pass++;
        end
        n_total++;
        if (instructions_emitted !== 32'd2 || format_error !== 1'b0)
            $display("FAIL basic_stats got emitted=%0d err=%b required 2/0",
                     instructions_emitted, format_error);
        else n_pass++;
        n_total++;
        if (byte_ready !== 1'b0 || instruction_valid !== 1'b0)
            $display("FAIL done_idle got rdy=%b vld=%b required 0/0",
                     byte_ready, instruction_valid);
        else n_pass++;
    endtask

    task automatic test_no_lf();
        logic [16:0] e0;
        e0 = {1'b1, 16'd1000};
        do_reset();
        send_str("R1000", 1'b1);
        wait_done();
        n_total++;
        if (rec.size() !== 1 || rec[0] !== e0)
            $display("FAIL no_lf got n=%0d first=%h required 1 %h",
                     rec.size(), rec.size() > 0 ? rec[0] : 17'h0, e0);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic ok;
        do_reset();
        instruction_ready = 1'b0;
        send_str("L5\n", 1'b0);
        for (int c = 0; c < 5; c++) begin
            ok = instruction_valid === 1'b1 && direction === 1'b0 &&
                 count === 16'd5 && byte_ready === 1'b0;
            n_total++;
            if (!ok)
                $display("FAIL stall_c%0d got vld=%b dir=%b cnt=%0d rdy=%b required 1/0/5/0",
                         c, instruction_valid, direction, count, byte_ready);
            else n_pass++;
            @(negedge clock);
        end
        instruction_ready = 1'b1;
        @(negedge clock);
        n_total++;
        if (instructions_emitted !== 32'd1 || rec.size() !== 1 || byte_ready !== 1'b1)
            $display("FAIL stall_release got emitted=%0d n=%0d rdy=%b required 1/1/1",
                     instructions_emitted, rec.size(), byte_ready);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [16:0] e0, e1;
        e0 = {1'b1, 16'd65535};
        e1 = {1'b0, 16'd3};
        do_reset();
        send_str("R99999\nL3\n", 1'b1);
        wait_done();
        n_total++;
        if (rec.size() !== 2)
            $display("FAIL ovf_n got %0d required 2", rec.size());
        else n_pass++;
        if (rec.size() == 2) begin
            n_total++;
            if (rec[0] !== e0 || rec[1] !== e1)
                $display("FAIL ovf_ins got %h,%h required %h,%h",
                         rec[0], rec[1], e0, e1);
            else n_pass++;
        end
        n_total++;
        if (format_error !== 1'b1 || error_count !== 32'd1)
            $display("FAIL ovf_err got flag=%b cnt=%0d required 1/1",
                     format_error, error_count);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [16:0] e0;
        e0 = {1'b0, 16'd7};
        do_reset();
        send_str("X\nR\nL7\n", 1'b1);
        wait_done();
        n_total++;
        if (rec.size() !== 1 || rec[0] !== e0)
            $display("FAIL err_ins got n=%0d first=%h required 1 %h",
                     rec.size(), rec.size() > 0 ? rec[0] : 17'h0, e0);
        else n_pass++;
        n_total++;
        if (error_count !== 32'd2 || instructions_emitted !== 32'd1)
            $display("FAIL err_cnt got errs=%0d emitted=%0d required 2/1",
                     error_count, instructions_emitted);
        else n_pass++;
    endtask

    task automatic test_reset_emit();
        logic [16:0] e0;
        e0 = {1'b0, 16'd1};
        do_reset();
        instruction_ready = 1'b0;
        send_str("R12\n", 1'b0);
        n_total++;
        if (instruction_valid !== 1'b1 || count !== 16'd12)
            $display("FAIL pre_reset got vld=%b cnt=%0d required 1/12",
                     instruction_valid, count);
        else n_pass++;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_total++;
        if ({instruction_valid, byte_ready, direction, done} !== 4'b0100 ||
            count !== 16'd0 || instructions_emitted !== 32'd0 || rec.size() !== 0)
            $display("FAIL mid_reset got vld=%b rdy=%b dir=%b done=%b cnt=%0d emitted=%0d n=%0d required 0/1/0/0/0/0/0",
                     instruction_valid, byte_ready, direction, done, count,
                     instructions_emitted, rec.size());
        else n_pass++;
        instruction_ready = 1'b1;
        send_str("L1\n", 1'b1);
        wait_done();
        n_total++;
        if (rec.size() !== 1 || rec[0] !== e0)
            $display("FAIL after_reset got n=%0d first=%h required 1 %h",
                     rec.size(), rec.size() > 0 ? rec[0] : 17'h0, e0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_lf();
        test_stall();
        test_overflow();
        test_errors();
        test_reset_emit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
